huffman_decoder: RTL and testbench

//  Streaming Huffman decoder for 4-bit symbols. Host presents a 6-bit MSB-first look-ahead window; block decodes one codeword per load.

---
 rtl/huffman_pkg.sv | 27 ++
 rtl/huffman_code_lut.sv | 65 ++++++
 rtl/huffman_decoder.sv | 125 ++++++++++++
 tb/tb_huffman_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg
//   Shared constants and types for the streaming Huffman decoder.
//   WIN_W/SYM_W/LEN_W  : window, symbol and consume-length widths (fixed by the code table)
//   LEN_1..LEN_10      : the only consume lengths the decoder ever reports
//   ESC_CODE           : window value that introduces a 4-bit literal when HUFF_ESCAPE_EN is defined
//   state_e            : decoder FSM states
package huffman_pkg;

    localparam int WIN_W = 6;
    localparam int SYM_W = 4;
    localparam int LEN_W = 4;

    localparam logic [LEN_W-1:0] LEN_1  = 4'd1;
    localparam logic [LEN_W-1:0] LEN_4  = 4'd4;
    localparam logic [LEN_W-1:0] LEN_5  = 4'd5;
    localparam logic [LEN_W-1:0] LEN_6  = 4'd6;
    localparam logic [LEN_W-1:0] LEN_10 = 4'd10;

    localparam logic [WIN_W-1:0] ESC_CODE = 6'b111111;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/huffman_code_lut.sv
// huffman_code_lut
//   Combinational code table: maps a 6-bit MSB-first window to the symbol it
//   starts with and the number of window bits that codeword occupies.
//   Optional feature macro: HUFF_ESCAPE_EN (adds the is_esc output; 111111 is
//   then the escape prefix instead of a length-6 padding code for symbol 0).
// Ports
//   win     in   6  look-ahead window, win[5] is the next stream bit
//   sym     out  4  decoded symbol
//   len     out  4  codeword length in bits
//   is_esc  out  1  window is the escape prefix (HUFF_ESCAPE_EN only)
module huffman_code_lut
    import huffman_pkg::*;
(
    input  logic [WIN_W-1:0] win,
    output logic [SYM_W-1:0] sym,
`ifdef HUFF_ESCAPE_EN
    output logic             is_esc,
`endif
    output logic [LEN_W-1:0] len
);

    // Prefix match; bits past the codeword are wildcards so undriven or
    // unknown trailing bits never reach the outputs.
    always_comb begin
        sym = 4'd0;
        len = LEN_6;
`ifdef HUFF_ESCAPE_EN
        is_esc = 1'b0;
`endif
        casez (win)
            6'b0?????: begin
                sym = 4'd0;
                len = LEN_1;
            end
            6'b10????: begin
                sym = 4'd1 + {2'b00, win[3:2]};
                len = LEN_4;
            end
            6'b110???: begin
                sym = 4'd5 + {2'b00, win[2:1]};
                len = LEN_5;
            end
            ESC_CODE: begin
`ifdef HUFF_ESCAPE_EN
                sym    = 4'd0;
                len    = LEN_10;
                is_esc = 1'b1;
`else
                // Without the literal path this is a padding/flush code.
                sym = 4'd0;
                len = LEN_6;
`endif
            end
            6'b111???: begin
                sym = 4'd9 + {1'b0, win[2:0]};
                len = LEN_6;
            end
            default: begin
                sym = 4'd0;
                len = LEN_6;
            end
        endcase
    end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder
//   Streaming Huffman decoder for 4-bit symbols. One codeword is decoded per
//   load; the result is presented for one cycle on ready together with the
//   number of window bits the host must discard.
//   Optional feature macro: HUFF_ESCAPE_EN (escape prefix 111111 followed by a
//   4-bit literal carried in the next window).
// Ports
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset
//   encodedData   in   6  bit window, [5] = next stream bit
//   load          in   1  window valid this cycle
//   ready         out  1  one-cycle pulse, decodedData/symbolLength valid
//   decodedData   out  4  decoded symbol
//   symbolLength  out  4  bits to consume: 1, 4, 5, 6 or 10
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIN_W-1:0] encodedData,
    input  logic             load,
    output logic             ready,
    output logic [SYM_W-1:0] decodedData,
    output logic [LEN_W-1:0] symbolLength
);

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [SYM_W-1:0]   lut_sym;
    logic [LEN_W-1:0]   lut_len;
`ifdef HUFF_ESCAPE_EN
    logic               lut_esc;
    logic               esc_pending_q, esc_pending_d;
`endif

    huffman_code_lut u_lut (
        .win    (encodedData),
        .sym    (lut_sym),
`ifdef HUFF_ESCAPE_EN
        .is_esc (lut_esc),
`endif
        .len    (lut_len)
    );

    // Next-state and next-output logic; outputs hold unless a response is issued.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        sym_d   = sym_q;
        len_d   = len_q;
`ifdef HUFF_ESCAPE_EN
        esc_pending_d = esc_pending_q;
`endif
        case (state_q)
            ST_PRIME: begin
                // Fill request: ask the host for a full window, not a symbol.
                ready_d = 1'b1;
                sym_d   = 4'd0;
                len_d   = LEN_6;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (load) begin
                    ready_d = 1'b1;
                    state_d = ST_RESP;
`ifdef HUFF_ESCAPE_EN
                    if (esc_pending_q) begin
                        // Window after an escape carries a raw 4-bit literal.
                        sym_d         = encodedData[5:2];
                        len_d         = LEN_4;
                        esc_pending_d = 1'b0;
                    end else if (lut_esc) begin
                        sym_d         = 4'd0;
                        len_d         = LEN_10;
                        esc_pending_d = 1'b1;
                    end else begin
                        sym_d = lut_sym;
                        len_d = lut_len;
                    end
`else
                    sym_d = lut_sym;
                    len_d = lut_len;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                // load is deliberately ignored while the response is shown.
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PRIME;
            ready_q <= 1'b0;
            sym_q   <= 4'd0;
            len_q   <= LEN_6;
`ifdef HUFF_ESCAPE_EN
            esc_pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            sym_q   <= sym_d;
            len_q   <= len_d;
`ifdef HUFF_ESCAPE_EN
            esc_pending_q <= esc_pending_d;
`endif
        end
    end

    assign ready        = ready_q;
    assign decodedData  = sym_q;
    assign symbolLength = len_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder
//   Scoreboard bench for huffman_decoder. The driver pushes the expected
//   {symbol, length} of every decode it causes; a monitor pops and compares on
//   each ready pulse and checks the reset state. Works with or without
//   HUFF_ESCAPE_EN (the reference model follows the same macro).
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] encodedData = 6'd0;
    logic       load = 1'b0;
    logic       ready;
    logic [3:0] decodedData;
    logic [3:0] symbolLength;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       esc_m = 1'b0;
    logic       fin_req = 1'b0;
    logic       fin_done = 1'b0;

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .encodedData  (encodedData),
        .load         (load),
        .ready        (ready),
        .decodedData  (decodedData),
        .symbolLength (symbolLength)
    );

    // Reference model: decode from the code-table rules (leading-one count).
    task automatic model(input logic [5:0] w, output logic [3:0] s, output logic [3:0] l);
        int ones;
        ones = 0;
        for (int i = 5; i >= 0; i--) begin
            if (w[i] && ones == 5 - i) ones++;
        end
        if (esc_m) begin
            s = w[5:2]; l = 4'd4; esc_m = 1'b0;
        end else if (ones == 0) begin
            s = 4'd0; l = 4'd1;
        end else if (ones == 1) begin
            s = 4'(1 + int'(w[3:2])); l = 4'd4;
        end else if (ones == 2) begin
            s = 4'(5 + int'(w[2:1])); l = 4'd5;
        end else if (w[2:0] == 3'd7) begin
`ifdef HUFF_ESCAPE_EN
            s = 4'd0; l = 4'd10; esc_m = 1'b1;
`else
            s = 4'd0; l = 4'd6;
`endif
        end else begin
            s = 4'(9 + int'(w[2:0])); l = 4'd6;
        end
    endtask

    task automatic push_model(input logic [5:0] w, input int n);
        logic [3:0] s, l;
        for (int k = 0; k < n; k++) begin
            model(w, s, l);
            exp_q.push_back({s, l});
        end
    endtask

    // Entry/exit invariant: #1 after an edge, next edge is a WAIT-state edge.
    task automatic drive(input logic [5:0] w, input int hold, input int gap);
        encodedData = w;
        load = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        load = 1'b0;
        encodedData = 6'($urandom);
        if (hold % 2 == 1) begin @(posedge clk); #1; end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic dir(input logic [5:0] w, input logic [3:0] es, input logic [3:0] el);
        exp_q.push_back({es, el});
        drive(w, 1, $urandom_range(0, 2));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        encodedData = 6'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        esc_m = 1'b0;
        exp_q.push_back({4'd0, 4'd6});
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Monitor: reset-state checks and scoreboard compare on every ready pulse.
    initial begin : monitor
        logic       rst_prev;
        logic [7:0] e;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rst_prev) begin
                checks++;
                if (ready !== 1'b0 || decodedData !== 4'd0 || symbolLength !== 4'd6) begin
                    errors++;
                    $display("FAIL reset_state got ready=%0b sym=%0d len=%0d required ready=0 sym=0 len=6",
                             ready, decodedData, symbolLength);
                end
            end else if (!rst && ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready got sym=%0d len=%0d required no pulse",
                             decodedData, symbolLength);
                end else begin
                    e = exp_q.pop_front();
                    if ({decodedData, symbolLength} !== e) begin
                        errors++;
                        $display("FAIL decode got sym=%0d len=%0d required sym=%0d len=%0d",
                                 decodedData, symbolLength, e[7:4], e[3:0]);
                    end
                end
            end
            if (fin_req && !fin_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_ready got %0d outstanding required 0", exp_q.size());
                end
                fin_done = 1'b1;
            end
            rst_prev = rst;
        end
    end

    initial begin : stimulus
        string      stream;
        int         pos;
        logic [5:0] w;
        logic [3:0] s, l;

        do_reset();

        // Directed code-table points.
        dir({1'b0, 5'($urandom)}, 4'd0, 4'd1);
        dir({4'b1011, 2'($urandom)}, 4'd4, 4'd4);
        dir({4'b1000, 2'($urandom)}, 4'd1, 4'd4);
        dir({5'b11010, 1'($urandom)}, 4'd7, 4'd5);
        dir({5'b11011, 1'($urandom)}, 4'd8, 4'd5);
        dir(6'b111000, 4'd9, 4'd6);
        dir(6'b111101, 4'd14, 4'd6);
        dir(6'b111110, 4'd15, 4'd6);
`ifdef HUFF_ESCAPE_EN
        dir(6'b111111, 4'd0, 4'd10);
        dir({4'b0111, 2'($urandom)}, 4'd7, 4'd4);
`else
        dir(6'b111111, 4'd0, 4'd6);
        dir({4'b0111, 2'($urandom)}, 4'd0, 4'd1);
`endif

        // load held across WAIT and RESP: RESP edge ignored, next WAIT decodes again.
        exp_q.push_back({4'd2, 4'd4});
        exp_q.push_back({4'd2, 4'd4});
        drive({4'b1001, 2'($urandom)}, 3, 1);
        exp_q.push_back({4'd5, 4'd5});
        drive({5'b11000, 1'($urandom)}, 2, 0);

        // Host shifting a bitstream by the reported lengths.
        stream = "00001011111101111111011111111111101111111";
        pos = 0;
        while (pos < stream.len()) begin
            for (int b = 0; b < 6; b++) begin
                if (pos + b < stream.len()) w[5-b] = (stream[pos+b] == "1");
                else                        w[5-b] = 1'($urandom);
            end
            model(w, s, l);
            exp_q.push_back({s, l});
            drive(w, 1, $urandom_range(0, 1));
            pos += (l == 4'd10) ? 6 : int'(l);
        end

        // Randomized windows, hold times and gaps.
        for (int n = 0; n < 80; n++) begin
            int hold;
            w = 6'($urandom);
            if ($urandom_range(0, 3) == 0) w = 6'b111111;
            hold = ($urandom_range(0, 7) == 0) ? 3 : 1;
            push_model(w, (hold + 1) / 2);
            drive(w, hold, $urandom_range(0, 3));
        end

        // Reset between an escape and its literal discards the pending literal.
        push_model(6'b111111, 1);
        drive(6'b111111, 1, 1);
        do_reset();
        dir({4'b0111, 2'($urandom)}, 4'd0, 4'd1);

        repeat (4) @(posedge clk);
        fin_req = 1'b1;
        for (int i = 0; i < 20 && !fin_done; i++) @(posedge clk);
        if (!fin_done) begin
            $display("FAIL final_check monitor did not respond");
            $fatal(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
